bellman_ford_relax: RTL and testbench
=====================================

BELLMAN_FORD_RELAX -- requirements
Module: bellman_ford_relax

Interface
REQ-001 Parameter NODES, 4: vertex count; the adjacency matrix and vertex matrix are NODES x NODES and NODES entries.
REQ-002 Parameter WEIGHT_WIDTH, 15: MSB index of the signed weight field, so the field is WEIGHT_WIDTH+1 bits.
REQ-003 Parameter PRED_WIDTH, 7: MSB index of the predecessor/index field, so the field is PRED_WIDTH+1 bits.
REQ-004 Parameter VERT_WIDTH, WEIGHT_WIDTH+PRED_WIDTH+2: vertex word width; bits [WEIGHT_WIDTH:0] hold the weight and bits [VERT_WIDTH-1:WEIGHT_WIDTH+1] hold the predecessor.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 relax_start  input  1  one-cycle start pulse.
REQ-008 src  input  PRED_WIDTH+1  source vertex index, sampled at relax_start.
REQ-009 adjmat  input  NODES x NODES x (WEIGHT_WIDTH+1) signed  edge weights; a value of 0 means there is no edge. Held stable while busy.
REQ-010 vertmat  output  NODES x VERT_WIDTH  distance and predecessor per vertex; feeds the cycle-detect stage.
REQ-011 relax_done  output  1  high while vertmat is final; drives the downstream stage's cycle_reset release.
REQ-012 relax_busy  output  1  high from the INIT state through the last relaxation.

Function
REQ-013 States are IDLE, INIT, READ, RELAX, NEXT and DONE. Any undefined encoding SHALL go to IDLE.
REQ-014 IDLE or DONE, relax_start=1: latch src into s, clear relax_done, then go to INIT.
REQ-015 relax_start in any other state SHALL be ignored.
REQ-016 INIT, one cycle:
- every vertex: weight = INF (+2^WEIGHT_WIDTH-1), pred = own index;
- vertmat[s]: weight 0;
- i=j=0, pass=0, changed=0;
- go to READ.
REQ-017 READ SHALL latch svw=weight[i], dvw=weight[j], e=adjmat[i][j], then go to RELAX.
REQ-018 RELAX: when e!=0, i!=j, svw!=INF, and sum<dvw, write weight[j]=sum, pred[j]=i, and set changed=1.
- sum is svw+e computed at WEIGHT_WIDTH+2 bits.
- sum is saturated to the range [-2^WEIGHT_WIDTH, 2^WEIGHT_WIDTH-2].
REQ-019 RELAX always proceeds to NEXT.
REQ-020 NEXT, when j+1<NODES: j increments and the state goes to READ.
REQ-021 NEXT, when j+1==NODES and i+1<NODES: i increments, j=0, and the state goes to READ.
REQ-022 NEXT, when i+1==NODES and j+1==NODES (end of pass):
- if changed==0 or pass+1==NODES-1, go to DONE;
- else pass increments, i=j=0, changed=0, go to READ.
REQ-023 Each edge SHALL cost exactly 3 cycles: READ, RELAX and NEXT.
REQ-024 Worst-case latency from the cycle after the start pulse to relax_done=1 SHALL be 1+3*NODES*NODES*(NODES-1)+1 cycles.
REQ-025 DONE: relax_done=1, relax_busy=0, and vertmat is held unchanged until the next accepted start.
REQ-026 vertmat SHALL change only in INIT and RELAX.
REQ-027 A relaxation SHALL be visible to a later READ in the same pass.
REQ-028 src>=NODES: INIT proceeds, no vertex gets weight 0, no relaxation occurs, and the block reaches DONE after one pass.

Reset
REQ-029 While reset_n=0, independent of clk:
- state=IDLE;
- relax_done=0, relax_busy=0;
- i, j, pass, changed and s are 0;
- every vertmat entry: weight=INF, pred=own index.
REQ-030 reset_n low mid-run SHALL abort the run without producing relax_done; after reset_n rises the block waits in IDLE for a new relax_start.
REQ-031 reset_n deassertion SHALL be synchronized internally so the first post-reset edge is glitch-free.

Verification
REQ-032 NODES=4, src=0, edges 0->1=5, 1->2=3, 0->2=10:
- pass 0 gives weights [0,5,8,INF] and preds [0,0,1,3];
- pass 1 makes no update, so relax_done=1 at cycle 1+48+48+1=98.
REQ-033 All-zero adjmat, src=2:
- weights [INF,INF,0,INF], preds [0,1,2,3];
- relax_done after 1+48+1=50 cycles.
REQ-034 Negative cycle 1->2=-4, 2->1=2, 0->1=1, src=0:
- the run uses the full 3 passes and ends at cycle 146;
- the vertmat loop 1<->2 is flagged by the downstream stage.
REQ-035 Saturation: WEIGHT_WIDTH=7, edges 0->1=-100, 1->2=-100, src=0 gives weight[2]=-128.
REQ-036 reset_n pulsed low during pass 1:
- all outputs return to reset values immediately;
- relax_start pulses during the reset are ignored;
- a fresh start reproduces REQ-032 exactly.
REQ-037 relax_start pulsed while busy is ignored, and the result is identical to an uninterrupted run.

Source files
------------

// File: rtl/bellman_ford_relax_if.sv
// Purpose: groups the relaxation engine's start/source/matrix inputs and result outputs.
// Latency: none; wires only.
// Backpressure: none; adjmat must stay stable while relax_busy is high.
interface bellman_ford_relax_if #(
  parameter int NODES        = 4,
  parameter int WEIGHT_WIDTH = 15,
  parameter int PRED_WIDTH   = 7,
  parameter int VERT_WIDTH   = WEIGHT_WIDTH + PRED_WIDTH + 2
);
  logic                                          relax_start;
  logic [PRED_WIDTH:0]                           src;
  logic signed [NODES-1:0][NODES-1:0][WEIGHT_WIDTH:0] adjmat;
  logic [NODES-1:0][VERT_WIDTH-1:0]              vertmat;
  logic                                          relax_done;
  logic                                          relax_busy;

  modport master (
    output relax_start, src, adjmat,
    input  vertmat, relax_done, relax_busy
  );

  modport slave (
    input  relax_start, src, adjmat,
    output vertmat, relax_done, relax_busy
  );
endinterface

// File: rtl/bellman_ford_relax.sv
// Purpose: sequential Bellman-Ford edge relaxation over a NODES x NODES adjacency matrix.
// Latency: 3 cycles per edge; worst case 2 + 3*NODES*NODES*(NODES-1) cycles start-to-done.
// Backpressure: none; relax_start is ignored while busy, vertmat holds in DONE until restarted.
module bellman_ford_relax #(
  parameter int NODES        = 4,
  parameter int WEIGHT_WIDTH = 15,
  parameter int PRED_WIDTH   = 7,
  parameter int VERT_WIDTH   = WEIGHT_WIDTH + PRED_WIDTH + 2
) (
  input logic                 clk,
  input logic                 reset_n,
  bellman_ford_relax_if.slave bus
);

  localparam int IW  = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int PSW = $clog2(NODES) + 1;

  localparam logic signed [WEIGHT_WIDTH:0]   INF     = (WEIGHT_WIDTH+1)'(2**WEIGHT_WIDTH - 1);
  localparam logic signed [WEIGHT_WIDTH+1:0] SUM_MIN = (WEIGHT_WIDTH+2)'(-(2**WEIGHT_WIDTH));
  localparam logic signed [WEIGHT_WIDTH+1:0] SUM_MAX = (WEIGHT_WIDTH+2)'(2**WEIGHT_WIDTH - 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    READ  = 3'd2,
    RELAX = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  logic [1:0]                       rst_sync_q, rst_sync_d;
  logic                             rst_n_int;
  state_t                           state_q, state_d;
  logic [PRED_WIDTH:0]              s_q, s_d;
  logic [IW-1:0]                    i_q, i_d, j_q, j_d;
  logic [PSW-1:0]                   pass_q, pass_d;
  logic                             changed_q, changed_d;
  logic signed [WEIGHT_WIDTH:0]     svw_q, svw_d, dvw_q, dvw_d, e_q, e_d;
  logic [NODES-1:0][VERT_WIDTH-1:0] vert_q, vert_d;
  logic signed [WEIGHT_WIDTH+1:0]   sum_raw;
  logic signed [WEIGHT_WIDTH:0]     sum_sat;
  logic                             relax_hit;

  // Reset asserts immediately but releases two clean edges after reset_n rises.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset release synchronizer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  // Candidate distance through vertex i, widened by one bit then clamped so it never equals INF.
  always_comb begin
    sum_raw = {svw_q[WEIGHT_WIDTH], svw_q} + {e_q[WEIGHT_WIDTH], e_q};
    sum_sat = sum_raw[WEIGHT_WIDTH:0];
    if (sum_raw < SUM_MIN)      sum_sat = SUM_MIN[WEIGHT_WIDTH:0];
    else if (sum_raw > SUM_MAX) sum_sat = SUM_MAX[WEIGHT_WIDTH:0];
    relax_hit = (e_q != '0) && (i_q != j_q) && (svw_q != INF) && (sum_sat < dvw_q);
  end

  // Next-state and datapath: one edge visited per READ/RELAX/NEXT triple, row-major.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    i_d       = i_q;
    j_d       = j_q;
    pass_d    = pass_q;
    changed_d = changed_q;
    svw_d     = svw_q;
    dvw_d     = dvw_q;
    e_d       = e_q;
    vert_d    = vert_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.relax_start) begin
          s_d     = bus.src;
          state_d = INIT;
        end
      end
      INIT: begin
        for (int k = 0; k < NODES; k++) begin
          vert_d[k] = {(PRED_WIDTH+1)'(k), INF};
          if (int'(s_q) == k) vert_d[k][WEIGHT_WIDTH:0] = '0;
        end
        i_d       = '0;
        j_d       = '0;
        pass_d    = '0;
        changed_d = 1'b0;
        state_d   = READ;
      end
      READ: begin
        svw_d   = vert_q[i_q][WEIGHT_WIDTH:0];
        dvw_d   = vert_q[j_q][WEIGHT_WIDTH:0];
        e_d     = bus.adjmat[i_q][j_q];
        state_d = RELAX;
      end
      RELAX: begin
        if (relax_hit) begin
          vert_d[j_q] = {(PRED_WIDTH+1)'(i_q), sum_sat};
          changed_d   = 1'b1;
        end
        state_d = NEXT;
      end
      NEXT: begin
        state_d = READ;
        if (int'(j_q) + 1 < NODES) begin
          j_d = j_q + 1'b1;
        end else if (int'(i_q) + 1 < NODES) begin
          i_d = i_q + 1'b1;
          j_d = '0;
        end else if (!changed_q || (int'(pass_q) + 1 == NODES - 1)) begin
          state_d = DONE;
        end else begin
          pass_d    = pass_q + 1'b1;
          i_d       = '0;
          j_d       = '0;
          changed_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q   <= IDLE;
      s_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      pass_q    <= '0;
      changed_q <= 1'b0;
      svw_q     <= '0;
      dvw_q     <= '0;
      e_q       <= '0;
      for (int k = 0; k < NODES; k++) vert_q[k] <= {(PRED_WIDTH+1)'(k), INF};
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      i_q       <= i_d;
      j_q       <= j_d;
      pass_q    <= pass_d;
      changed_q <= changed_d;
      svw_q     <= svw_d;
      dvw_q     <= dvw_d;
      e_q       <= e_d;
      vert_q    <= vert_d;
    end
  end

  assign bus.vertmat    = vert_q;
  assign bus.relax_done = (state_q == DONE);
  assign bus.relax_busy = state_q inside {INIT, READ, RELAX, NEXT};

endmodule

// File: tb/tb_bellman_ford_relax.sv
// Purpose: self-checking bench for bellman_ford_relax against a plain integer Bellman-Ford model.
// Latency: checks start-to-done cycle counts derived from the number of passes the model needs.
// Backpressure: exercises ignored starts while busy and during reset.
module tb_bellman_ford_relax;
  localparam int N   = 4;
  localparam int WW  = 15;
  localparam int WW7 = 7;
  localparam int PW  = 7;
  localparam int VW  = WW + PW + 2;
  localparam int VW7 = WW7 + PW + 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bellman_ford_relax_if #(.NODES(N), .WEIGHT_WIDTH(WW), .PRED_WIDTH(PW), .VERT_WIDTH(VW)) bus ();
  bellman_ford_relax #(.NODES(N), .WEIGHT_WIDTH(WW), .PRED_WIDTH(PW), .VERT_WIDTH(VW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  bellman_ford_relax_if #(.NODES(N), .WEIGHT_WIDTH(WW7), .PRED_WIDTH(PW), .VERT_WIDTH(VW7)) bus7 ();
  bellman_ford_relax #(.NODES(N), .WEIGHT_WIDTH(WW7), .PRED_WIDTH(PW), .VERT_WIDTH(VW7)) dut7 (
    .clk(clk), .reset_n(reset_n), .bus(bus7));

  int n_cmp  = 0;
  int n_fail = 0;
  int m_adj[N][N];
  int m_w[N];
  int m_p[N];
  int m_passes;

  // Reference: textbook Bellman-Ford with in-place updates, saturating sums, early exit.
  task automatic model_run(input int s, input int ww);
    int inf = (1 << ww) - 1;
    int lo  = -(1 << ww);
    int hi  = (1 << ww) - 2;
    bit changed;
    for (int k = 0; k < N; k++) begin
      m_w[k] = (k == s) ? 0 : inf;
      m_p[k] = k;
    end
    m_passes = 0;
    for (int p = 0; p < N - 1; p++) begin
      changed = 1'b0;
      m_passes++;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i != j && m_adj[i][j] != 0 && m_w[i] != inf) begin
            int sum;
            sum = m_w[i] + m_adj[i][j];
            if (sum < lo) sum = lo;
            if (sum > hi) sum = hi;
            if (sum < m_w[j]) begin
              m_w[j] = sum;
              m_p[j] = i;
              changed = 1'b1;
            end
          end
        end
      end
      if (!changed) break;
    end
  endtask

  task automatic clear_adj();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m_adj[i][j] = 0;
  endtask

  task automatic rand_adj(input int lo, input int hi);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m_adj[i][j] = ($urandom_range(0, 9) < 4) ? int'($urandom_range(0, hi - lo)) + lo : 0;
  endtask

  // Starts a run on the wide instance; lat counts INIT as cycle 1, -1 on timeout.
  task automatic run16(input int s, output int lat);
    int n;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) bus.adjmat[i][j] = 16'(m_adj[i][j]);
    bus.src = 8'(s);
    bus.relax_start = 1'b1;
    @(posedge clk); #1;
    bus.relax_start = 1'b0;
    n = 0;
    while (bus.relax_done !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    lat = (bus.relax_done === 1'b1) ? n + 1 : -1;
  endtask

  task automatic run7(input int s, output int lat);
    int n;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) bus7.adjmat[i][j] = 8'(m_adj[i][j]);
    bus7.src = 8'(s);
    bus7.relax_start = 1'b1;
    @(posedge clk); #1;
    bus7.relax_start = 1'b0;
    n = 0;
    while (bus7.relax_done !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    lat = (bus7.relax_done === 1'b1) ? n + 1 : -1;
  endtask

  task automatic test_reset();
    int gw, gp;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.relax_done !== 1'b0 || bus.relax_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: done=%b busy=%b, want 0 0", bus.relax_done, bus.relax_busy);
    end
    for (int k = 0; k < N; k++) begin
      gw = int'($signed(bus.vertmat[k][WW:0]));
      gp = int'(bus.vertmat[k][VW-1:WW+1]);
      n_cmp++;
      if (gw !== 32767 || gp !== k) begin
        n_fail++;
        $display("FAIL reset_vert[%0d]: w=%0d p=%0d, want w=32767 p=%0d", k, gw, gp, k);
      end
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.relax_busy !== 1'b0 || bus7.relax_busy !== 1'b0 || bus7.relax_done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b busy7=%b done7=%b, want 0 0 0",
               bus.relax_busy, bus7.relax_busy, bus7.relax_done);
    end
  endtask

  // Directed graphs: simple chain, empty graph, negative cycle.
  task automatic test_directed();
    int lat, gw, gp, s;
    for (int sc = 0; sc < 3; sc++) begin
      clear_adj();
      case (sc)
        0: begin m_adj[0][1] = 5;  m_adj[1][2] = 3;  m_adj[0][2] = 10; s = 0; end
        1: begin s = 2; end
        default: begin m_adj[1][2] = -4; m_adj[2][1] = 2; m_adj[0][1] = 1; s = 0; end
      endcase
      model_run(s, WW);
      run16(s, lat);
      n_cmp++;
      if (lat !== 2 + 3 * N * N * m_passes) begin
        n_fail++;
        $display("FAIL directed%0d_latency: got %0d, want %0d", sc, lat, 2 + 3 * N * N * m_passes);
      end
      for (int k = 0; k < N; k++) begin
        gw = int'($signed(bus.vertmat[k][WW:0]));
        gp = int'(bus.vertmat[k][VW-1:WW+1]);
        n_cmp++;
        if (gw !== m_w[k] || gp !== m_p[k]) begin
          n_fail++;
          $display("FAIL directed%0d_vert[%0d]: w=%0d p=%0d, want w=%0d p=%0d", sc, k, gw, gp, m_w[k], m_p[k]);
        end
      end
      n_cmp++;
      if (bus.relax_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL directed%0d_busy_in_done: got %b, want 0", sc, bus.relax_busy);
      end
    end
  endtask

  task automatic test_random();
    int lat, gw, gp, s;
    for (int it = 0; it < 12; it++) begin
      rand_adj(-15, 45);
      s = int'($urandom_range(0, N - 1));
      model_run(s, WW);
      run16(s, lat);
      n_cmp++;
      if (lat !== 2 + 3 * N * N * m_passes) begin
        n_fail++;
        $display("FAIL random%0d_latency: got %0d, want %0d", it, lat, 2 + 3 * N * N * m_passes);
      end
      for (int k = 0; k < N; k++) begin
        gw = int'($signed(bus.vertmat[k][WW:0]));
        gp = int'(bus.vertmat[k][VW-1:WW+1]);
        n_cmp++;
        if (gw !== m_w[k] || gp !== m_p[k]) begin
          n_fail++;
          $display("FAIL random%0d_vert[%0d]: w=%0d p=%0d, want w=%0d p=%0d", it, k, gw, gp, m_w[k], m_p[k]);
        end
      end
    end
  endtask

  task automatic test_src_out_of_range();
    int lat, gw, gp, s;
    rand_adj(-10, 30);
    s = N + int'($urandom_range(0, 200));
    model_run(s, WW);
    run16(s, lat);
    n_cmp++;
    if (lat !== 2 + 3 * N * N) begin
      n_fail++;
      $display("FAIL src_oob_latency: got %0d, want %0d", lat, 2 + 3 * N * N);
    end
    for (int k = 0; k < N; k++) begin
      gw = int'($signed(bus.vertmat[k][WW:0]));
      gp = int'(bus.vertmat[k][VW-1:WW+1]);
      n_cmp++;
      if (gw !== m_w[k] || gp !== m_p[k]) begin
        n_fail++;
        $display("FAIL src_oob_vert[%0d]: w=%0d p=%0d, want w=%0d p=%0d", k, gw, gp, m_w[k], m_p[k]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int n, gw, gp, s;
    rand_adj(-15, 45);
    s = int'($urandom_range(0, N - 1));
    model_run(s, WW);
    @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) bus.adjmat[i][j] = 16'(m_adj[i][j]);
    bus.src = 8'(s);
    bus.relax_start = 1'b1;
    @(posedge clk); #1;
    bus.relax_start = 1'b0;
    n = 0;
    while (bus.relax_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      if (n % 7 == 3 && bus.relax_busy === 1'b1) begin
        bus.src = 8'((s + 1 + int'($urandom_range(0, 2))) % N);
        bus.relax_start = 1'b1;
      end
      @(posedge clk); #1;
      bus.relax_start = 1'b0;
      n++;
    end
    n_cmp++;
    if (n + 1 !== 2 + 3 * N * N * m_passes) begin
      n_fail++;
      $display("FAIL busy_start_latency: got %0d, want %0d", n + 1, 2 + 3 * N * N * m_passes);
    end
    for (int k = 0; k < N; k++) begin
      gw = int'($signed(bus.vertmat[k][WW:0]));
      gp = int'(bus.vertmat[k][VW-1:WW+1]);
      n_cmp++;
      if (gw !== m_w[k] || gp !== m_p[k]) begin
        n_fail++;
        $display("FAIL busy_start_vert[%0d]: w=%0d p=%0d, want w=%0d p=%0d", k, gw, gp, m_w[k], m_p[k]);
      end
    end
  endtask

  // Result must hold in DONE while adjmat moves, then a new start is accepted from DONE.
  task automatic test_back_to_back();
    int lat, gw, gp, s;
    rand_adj(-15, 45);
    s = int'($urandom_range(0, N - 1));
    model_run(s, WW);
    run16(s, lat);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.adjmat[c % N][(c + 1) % N] = 16'(int'($urandom_range(1, 60)));
    end
    n_cmp++;
    if (bus.relax_done !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_done: got %b, want 1", bus.relax_done);
    end
    for (int k = 0; k < N; k++) begin
      gw = int'($signed(bus.vertmat[k][WW:0]));
      gp = int'(bus.vertmat[k][VW-1:WW+1]);
      n_cmp++;
      if (gw !== m_w[k] || gp !== m_p[k]) begin
        n_fail++;
        $display("FAIL hold_vert[%0d]: w=%0d p=%0d, want w=%0d p=%0d", k, gw, gp, m_w[k], m_p[k]);
      end
    end
    rand_adj(-15, 45);
    s = (s + 1) % N;
    model_run(s, WW);
    run16(s, lat);
    n_cmp++;
    if (lat !== 2 + 3 * N * N * m_passes) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d, want %0d", lat, 2 + 3 * N * N * m_passes);
    end
    for (int k = 0; k < N; k++) begin
      gw = int'($signed(bus.vertmat[k][WW:0]));
      gp = int'(bus.vertmat[k][VW-1:WW+1]);
      n_cmp++;
      if (gw !== m_w[k] || gp !== m_p[k]) begin
        n_fail++;
        $display("FAIL b2b_vert[%0d]: w=%0d p=%0d, want w=%0d p=%0d", k, gw, gp, m_w[k], m_p[k]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int lat, gw, gp;
    clear_adj();
    m_adj[0][1] = 5; m_adj[1][2] = 3; m_adj[0][2] = 10;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) bus.adjmat[i][j] = 16'(m_adj[i][j]);
    bus.src = 8'd0;
    bus.relax_start = 1'b1;
    @(negedge clk);
    bus.relax_start = 1'b0;
    repeat (60) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.relax_done !== 1'b0 || bus.relax_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_flags: done=%b busy=%b, want 0 0", bus.relax_done, bus.relax_busy);
    end
    for (int k = 0; k < N; k++) begin
      gw = int'($signed(bus.vertmat[k][WW:0]));
      gp = int'(bus.vertmat[k][VW-1:WW+1]);
      n_cmp++;
      if (gw !== 32767 || gp !== k) begin
        n_fail++;
        $display("FAIL midrun_reset_vert[%0d]: w=%0d p=%0d, want w=32767 p=%0d", k, gw, gp, k);
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.relax_start = 1'b1;
      @(negedge clk);
      bus.relax_start = 1'b0;
    end
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (bus.relax_done !== 1'b0 || bus.relax_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_idle_after: done=%b busy=%b, want 0 0", bus.relax_done, bus.relax_busy);
    end
    model_run(0, WW);
    run16(0, lat);
    n_cmp++;
    if (lat !== 2 + 3 * N * N * m_passes) begin
      n_fail++;
      $display("FAIL midrun_rerun_latency: got %0d, want %0d", lat, 2 + 3 * N * N * m_passes);
    end
    for (int k = 0; k < N; k++) begin
      gw = int'($signed(bus.vertmat[k][WW:0]));
      gp = int'(bus.vertmat[k][VW-1:WW+1]);
      n_cmp++;
      if (gw !== m_w[k] || gp !== m_p[k]) begin
        n_fail++;
        $display("FAIL midrun_rerun_vert[%0d]: w=%0d p=%0d, want w=%0d p=%0d", k, gw, gp, m_w[k], m_p[k]);
      end
    end
  endtask

  // Narrow weights: directed negative chain then random graphs hitting both clamps.
  task automatic test_saturation();
    int lat, gw, gp, s;
    for (int it = 0; it < 7; it++) begin
      if (it == 0) begin
        clear_adj();
        m_adj[0][1] = -100; m_adj[1][2] = -100;
        s = 0;
      end else begin
        rand_adj(-100, 100);
        s = int'($urandom_range(0, N - 1));
      end
      model_run(s, WW7);
      run7(s, lat);
      n_cmp++;
      if (lat !== 2 + 3 * N * N * m_passes) begin
        n_fail++;
        $display("FAIL sat%0d_latency: got %0d, want %0d", it, lat, 2 + 3 * N * N * m_passes);
      end
      for (int k = 0; k < N; k++) begin
        gw = int'($signed(bus7.vertmat[k][WW7:0]));
        gp = int'(bus7.vertmat[k][VW7-1:WW7+1]);
        n_cmp++;
        if (gw !== m_w[k] || gp !== m_p[k]) begin
          n_fail++;
          $display("FAIL sat%0d_vert[%0d]: w=%0d p=%0d, want w=%0d p=%0d", it, k, gw, gp, m_w[k], m_p[k]);
        end
      end
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.relax_start  = 1'b0;
    bus.src          = '0;
    bus.adjmat       = '0;
    bus7.relax_start = 1'b0;
    bus7.src         = '0;
    bus7.adjmat      = '0;
    test_reset();
    test_directed();
    test_random();
    test_src_out_of_range();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midrun();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
